// File: rtl/tpu_sequencer.sv
// tpu_sequencer: start/done control FSM that loads a weight tile, then streams skewed input tiles through the systolic array.
// Define TPU_SEQ_PERF_CNT_EN to enable the busy_cycles performance counter (tied to 0 otherwise).
module tpu_sequencer #(
    parameter int WIDTH_HEIGHT  = 16,
    parameter int ADDR_WIDTH    = 8,
    parameter int TILE_W        = 8,
    parameter int ARRAY_LATENCY = 17
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [TILE_W-1:0]                  num_tiles,
    input  logic [ADDR_WIDTH-1:0]              weight_rd_addr_base,
    input  logic [ADDR_WIDTH-1:0]              input_rd_addr_base,
    input  logic [ADDR_WIDTH-1:0]              output_wr_addr_base,
    output logic                               busy,
    output logic                               done,
    output logic [WIDTH_HEIGHT-1:0]            weightMem_rd_en,
    output logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] weightMem_rd_addr,
    output logic [WIDTH_HEIGHT-1:0]            fifo_en,
    output logic [WIDTH_HEIGHT-1:0]            weight_write,
    output logic                               sys_active,
    output logic [WIDTH_HEIGHT-1:0]            inputMem_rd_en,
    output logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] inputMem_rd_addr,
    output logic [WIDTH_HEIGHT-1:0]            outputMem_wr_en,
    output logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] outputMem_wr_addr,
    output logic [31:0]                        busy_cycles
);
    localparam int WH = WIDTH_HEIGHT;
    localparam int AW = ADDR_WIDTH;
    localparam int L  = ARRAY_LATENCY;
    localparam int CW = $clog2(2*WH + L + 1);
    localparam logic [CW-1:0] C_LOAD   = CW'(WH);
    localparam logic [CW-1:0] C_STREAM = CW'(2*WH - 2);
    localparam logic [CW-1:0] C_FLUSH  = CW'(L - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, COMMIT, STREAM, FLUSH, FIN} state_t;
    state_t state, state_nx;

    logic [CW-1:0]      cnt;
    logic [TILE_W-1:0]  n_tiles, k;
    logic [AW-1:0]      w_base, in_base, out_base, tile_off;
    logic [WH-1:0]      rd_en_nx;
    logic [WH*AW-1:0]   rd_addr_nx;
    logic               w_rd;
    logic [WH-1:0]      d_en   [L];
    logic [WH*AW-1:0]   d_addr [L];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (num_tiles == '0) ? FIN : LOAD_W;
            LOAD_W:  if (cnt == C_LOAD) state_nx = COMMIT;
            COMMIT:  state_nx = STREAM;
            STREAM:  if (cnt == C_STREAM) state_nx = FLUSH;
            FLUSH:   if (cnt == C_FLUSH) state_nx = ((k + TILE_W'(1)) < n_tiles) ? STREAM : FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Diagonal skew: lane i runs WH cycles starting at t=i, reading row t-i of the current tile.
    always_comb begin
        rd_en_nx   = '0;
        rd_addr_nx = '0;
        for (int i = 0; i < WH; i++) begin
            rd_en_nx[i] = state == STREAM && cnt >= CW'(i) && cnt < CW'(i + WH);
            rd_addr_nx[i*AW +: AW] = rd_en_nx[i] ? in_base + tile_off + AW'(cnt - CW'(i)) : '0;
        end
    end

    assign w_rd = state == LOAD_W && cnt < C_LOAD;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            k        <= '0;
            n_tiles  <= '0;
            w_base   <= '0;
            in_base  <= '0;
            out_base <= '0;
            tile_off <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx == state) ? cnt + CW'(1) : '0;
            if (state == IDLE && start) begin
                n_tiles  <= num_tiles;
                w_base   <= weight_rd_addr_base;
                in_base  <= input_rd_addr_base;
                out_base <= output_wr_addr_base;
            end
            if (state == COMMIT) begin
                k        <= '0;
                tile_off <= '0;
            end else if (state == FLUSH && cnt == C_FLUSH) begin
                k        <= k + TILE_W'(1);
                tile_off <= tile_off + AW'(WH);
            end
        end
    end

    // Outputs lag the state by one register stage; writes trail reads by exactly L cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy              <= 1'b0;
            done              <= 1'b0;
            weightMem_rd_en   <= '0;
            weightMem_rd_addr <= '0;
            fifo_en           <= '0;
            weight_write      <= '0;
            sys_active        <= 1'b0;
            inputMem_rd_en    <= '0;
            inputMem_rd_addr  <= '0;
            for (int s = 0; s < L; s++) begin
                d_en[s]   <= '0;
                d_addr[s] <= '0;
            end
        end else begin
            busy              <= (state == IDLE) ? start : (state != FIN);
            done              <= state == FIN;
            weightMem_rd_en   <= {WH{w_rd}};
            weightMem_rd_addr <= w_rd ? {WH{w_base + AW'(cnt)}} : '0;
            fifo_en           <= {WH{state == LOAD_W && cnt != '0}};
            weight_write      <= {WH{state == COMMIT}};
            sys_active        <= |inputMem_rd_en;
            inputMem_rd_en    <= rd_en_nx;
            inputMem_rd_addr  <= rd_addr_nx;
            d_en[0]           <= inputMem_rd_en;
            for (int i = 0; i < WH; i++)
                d_addr[0][i*AW +: AW] <= inputMem_rd_en[i] ?
                    inputMem_rd_addr[i*AW +: AW] - in_base + out_base : '0;
            for (int s = 1; s < L; s++) begin
                d_en[s]   <= d_en[s-1];
                d_addr[s] <= d_addr[s-1];
            end
        end
    end

    assign outputMem_wr_en   = d_en[L-1];
    assign outputMem_wr_addr = d_addr[L-1];

`ifdef TPU_SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && start))
            busy_cycles <= '0;
        else if (busy && !(&busy_cycles))
            busy_cycles <= busy_cycles + 32'd1;
    end
`else
    assign busy_cycles = '0;
`endif
endmodule
